// File: rtl/i2s_pkg.sv
// Shared types and default geometry for the I2S output stage.
package i2s_pkg;

    typedef enum logic {I2S_IDLE = 1'b0, I2S_RUN = 1'b1} i2s_state_t;

    localparam int I2S_WIDTH      = 24;
    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_BCLK_DIV   = 8;
    localparam int I2S_FIFO_DEPTH = 4;

    // Word select leads the channel MSB by one bit: high from the last left bit to the second-last right bit.
    function automatic logic i2s_ws(input int pos, input int slot_bits);
        return (pos >= slot_bits - 1) && (pos <= 2 * slot_bits - 2);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with registered full flag and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH,
    parameter int DEPTH = I2S_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic [LW-1:0]    w_count_next;
    logic             r_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_count == {LW{1'b0}});
    assign w_push  = push && !r_full;
    assign w_pop   = pop && !w_empty;

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Sample storage; validity is carried by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer, count and full-flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {LW{1'b0}};
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == LVL_FULL);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = w_empty;
    assign level = r_count;

endmodule

// File: rtl/i2s_serializer.sv
// Mono-to-stereo I2S transmitter with BCLK/LRCLK generation and a sample FIFO.
// Define I2S_UNDERRUN_REPEAT_EN to repeat the previous sample on underrun instead of sending silence.
module i2s_serializer
    import i2s_pkg::*;
#(
    parameter int WIDTH      = I2S_WIDTH,
    parameter int SLOT_BITS  = I2S_SLOT_BITS,
    parameter int BCLK_DIV   = I2S_BCLK_DIV,
    parameter int FIFO_DEPTH = I2S_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            enable,
    input  logic [WIDTH-1:0]                sample_in,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    output logic                            bclk,
    output logic                            lrclk,
    output logic                            sdata,
    output logic                            underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    localparam int P_W   = $clog2(2 * SLOT_BITS);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [P_W-1:0]   P_LAST   = P_W'(2 * SLOT_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

    i2s_state_t       r_state;
    i2s_state_t       w_state_next;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic [P_W-1:0]   r_pos;
    logic [P_W-1:0]   w_pos_next;
    logic [WIDTH-1:0] r_frame;
    logic [WIDTH-1:0] w_frame_next;
    logic             r_bclk, r_lrclk, r_sdata, r_underrun;
    logic             w_bclk_next, w_lrclk_next, w_sdata_next, w_underrun_next;
    logic             w_wrap, w_frame_end, w_pop, w_push;
    logic             w_full, w_empty;
    logic [WIDTH-1:0] w_head;

    // Bit of the frame sent at position pos; bits past WIDTH in a slot are zero padding.
    function automatic logic slot_bit(input logic [WIDTH-1:0] frame, input logic [P_W-1:0] pos);
        int               q;
        logic [WIDTH-1:0] sh;
        q = int'(pos);
        if (q >= SLOT_BITS) begin
            q = q - SLOT_BITS;
        end else begin
            q = q;
        end
        sh = frame << q;
        if (q < WIDTH) begin
            return sh[WIDTH-1];
        end else begin
            return 1'b0;
        end
    endfunction

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .din   (sample_in),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign w_push      = sample_valid && !w_full;
    assign w_wrap      = (r_state == I2S_RUN) && (r_div == DIV_LAST);
    assign w_frame_end = w_wrap && (r_pos == P_LAST);
    assign w_pop       = enable && ((r_state == I2S_IDLE) || w_frame_end);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= I2S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start immediately, stop only at a frame boundary.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            I2S_IDLE: begin
                if (enable) w_state_next = I2S_RUN;
                else        w_state_next = I2S_IDLE;
            end
            I2S_RUN: begin
                if (w_frame_end && !enable) w_state_next = I2S_IDLE;
                else                        w_state_next = I2S_RUN;
            end
            default: w_state_next = I2S_IDLE;
        endcase
    end

    // Divider, frame position, frame load and serial outputs.
    always_comb begin
        w_underrun_next = w_pop && w_empty;
        w_frame_next    = r_frame;
        if (w_pop) begin
            if (!w_empty) begin
                w_frame_next = w_head;
            end else begin
`ifdef I2S_UNDERRUN_REPEAT_EN
                w_frame_next = r_frame;
`else
                w_frame_next = {WIDTH{1'b0}};
`endif
            end
        end else begin
            w_frame_next = r_frame;
        end

        w_div_next   = {DIV_W{1'b0}};
        w_pos_next   = {P_W{1'b0}};
        w_bclk_next  = 1'b0;
        w_lrclk_next = 1'b0;
        w_sdata_next = 1'b0;
        case (r_state)
            I2S_IDLE: begin
                if (enable) w_sdata_next = slot_bit(w_frame_next, {P_W{1'b0}});
                else        w_sdata_next = 1'b0;
            end
            I2S_RUN: begin
                w_div_next  = w_wrap ? {DIV_W{1'b0}} : r_div + 1'b1;
                w_bclk_next = (w_div_next >= DIV_HALF);
                if (w_frame_end && !enable) begin
                    w_pos_next   = {P_W{1'b0}};
                    w_lrclk_next = 1'b0;
                    w_sdata_next = 1'b0;
                end else if (w_wrap) begin
                    w_pos_next   = w_frame_end ? {P_W{1'b0}} : r_pos + 1'b1;
                    w_lrclk_next = i2s_ws(int'(w_pos_next), SLOT_BITS);
                    w_sdata_next = slot_bit(w_frame_next, w_pos_next);
                end else begin
                    w_pos_next   = r_pos;
                    w_lrclk_next = r_lrclk;
                    w_sdata_next = r_sdata;
                end
            end
            default: begin
                w_div_next = {DIV_W{1'b0}};
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div      <= {DIV_W{1'b0}};
            r_pos      <= {P_W{1'b0}};
            r_frame    <= {WIDTH{1'b0}};
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_div      <= w_div_next;
            r_pos      <= w_pos_next;
            r_frame    <= w_frame_next;
            r_bclk     <= w_bclk_next;
            r_lrclk    <= w_lrclk_next;
            r_sdata    <= w_sdata_next;
            r_underrun <= w_underrun_next;
        end
    end

    assign sample_ready = !w_full;
    assign bclk         = r_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_serializer.sv
// Directed self-checking bench for i2s_serializer (default geometry 24/32/8/4).
module tb_i2s_serializer;
    localparam int WIDTH      = 24;
    localparam int SLOT_BITS  = 32;
    localparam int BCLK_DIV   = 8;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] sample_in = 24'h0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, bclk, lrclk, sdata, underrun;
    logic [2:0]  fifo_level;

    int n_vec = 0;
    int n_miss = 0;
    int urun_cnt = 0;
    int urun_long = 0;
    logic urun_prev = 1'b0;
    int per_min, per_max;
    logic [255:0] cap_sd, cap_ws;

    localparam logic [63:0] WS_EXP = 64'h00000001_FFFFFFFE;

    always #5 clk = ~clk;

    i2s_serializer #(
        .WIDTH      (WIDTH),
        .SLOT_BITS  (SLOT_BITS),
        .BCLK_DIV   (BCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    // Count underrun pulses and any pulse lasting more than one cycle.
    always @(negedge clk) begin
        if (underrun) urun_cnt <= urun_cnt + 1;
        if (underrun && urun_prev) urun_long <= urun_long + 1;
        urun_prev <= underrun;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push1(input logic [23:0] d);
        sample_in    = d;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic check_quiet(input string tag, input int ncyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            seen = seen | bclk | lrclk | sdata;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    // Sample sdata/lrclk at each BCLK rise, MSB-first; drop enable after stop_after bits.
    task automatic capture(input int nbits, input int stop_after,
                           output logic [255:0] sd, output logic [255:0] ws);
        logic prev;
        int   got, cyc, since;
        prev = bclk; got = 0; cyc = 0; since = 0;
        sd = '0; ws = '0;
        while (got < nbits && cyc < nbits * BCLK_DIV + 64) begin
            @(negedge clk);
            cyc++; since++;
            if (bclk && !prev) begin
                sd = {sd[254:0], sdata};
                ws = {ws[254:0], lrclk};
                if (got > 0) begin
                    if (since < per_min) per_min = since;
                    if (since > per_max) per_max = since;
                end
                since = 0;
                got++;
                if (got == stop_after) enable = 1'b0;
            end
            prev = bclk;
        end
        chk("capture_bits", 64'(got), 64'(nbits));
    endtask

    logic [63:0] exp_frames [4];
    logic [23:0] vec5 [5];

    initial begin
        exp_frames[0] = 64'h80000100_80000100;
        exp_frames[1] = 64'hA5A5A500_A5A5A500;
        exp_frames[2] = 64'h7FFFFF00_7FFFFF00;
`ifdef I2S_UNDERRUN_REPEAT_EN
        exp_frames[3] = 64'h7FFFFF00_7FFFFF00;
`else
        exp_frames[3] = 64'h00000000_00000000;
`endif
        vec5[0] = 24'h000001; vec5[1] = 24'hFFFFFF; vec5[2] = 24'h5A5A5A;
        vec5[3] = 24'h800000; vec5[4] = 24'h111111;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bclk",  64'(bclk), 64'd0);
        chk("rst_lrclk", 64'(lrclk), 64'd0);
        chk("rst_sdata", 64'(sdata), 64'd0);
        chk("rst_urun",  64'(underrun), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_ready", 64'(sample_ready), 64'd1);
        rstn = 1'b1;
        @(negedge clk);

        // Pushes while idle
        push1(24'h800001); push1(24'hA5A5A5); push1(24'h7FFFFF);
        @(negedge clk);
        chk("idle_level", 64'(fifo_level), 64'd3);
        chk("idle_ready", 64'(sample_ready), 64'd1);
        check_quiet("idle_quiet", 20);

        // Three full frames then one underrun frame; stop at the end of the fourth
        per_min = 1000; per_max = 0;
        enable = 1'b1;
        capture(256, 256, cap_sd, cap_ws);
        for (int f = 0; f < 4; f++) begin
            chk($sformatf("frame%0d_sdata", f), cap_sd[255-64*f -: 64], exp_frames[f]);
            chk($sformatf("frame%0d_lrclk", f), cap_ws[255-64*f -: 64], WS_EXP);
        end
        chk("bclk_period_min", 64'(per_min), 64'(BCLK_DIV));
        chk("bclk_period_max", 64'(per_max), 64'(BCLK_DIV));
        repeat (8) @(negedge clk);
        chk("urun_count", 64'(urun_cnt), 64'd1);
        chk("urun_width", 64'(urun_long), 64'd0);
        chk("drained_level", 64'(fifo_level), 64'd0);
        check_quiet("stop_quiet", 24);

        // Fill to full while stopped; fifth push is dropped
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_in = vec5[i];
            @(negedge clk);
            if (i == 2) chk("ready_at3", 64'(sample_ready), 64'd1);
            if (i == 3) chk("ready_at4", 64'(sample_ready), 64'd0);
        end
        sample_valid = 1'b0;
        @(negedge clk);
        chk("full_level", 64'(fifo_level), 64'd4);
        chk("full_ready", 64'(sample_ready), 64'd0);

        // Drop enable at p=10: frame still completes, then idle with FIFO intact
        enable = 1'b1;
        capture(64, 11, cap_sd, cap_ws);
        chk("midstop_sdata", cap_sd[63:0], 64'h00000100_00000100);
        chk("midstop_lrclk", cap_ws[63:0], WS_EXP);
        repeat (8) @(negedge clk);
        check_quiet("midstop_quiet", 24);
        chk("midstop_level", 64'(fifo_level), 64'd3);
        chk("midstop_ready", 64'(sample_ready), 64'd1);
        chk("midstop_urun", 64'(urun_cnt), 64'd1);

        // Asynchronous reset mid-frame
        enable = 1'b1;
        repeat (100) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_bclk",  64'(bclk), 64'd0);
        chk("arst_lrclk", 64'(lrclk), 64'd0);
        chk("arst_sdata", 64'(sdata), 64'd0);
        chk("arst_urun",  64'(underrun), 64'd0);
        chk("arst_level", 64'(fifo_level), 64'd0);
        chk("arst_ready", 64'(sample_ready), 64'd1);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Recovery after reset
        push1(24'hC00003);
        enable = 1'b1;
        capture(64, 64, cap_sd, cap_ws);
        chk("recover_sdata", cap_sd[63:0], 64'hC0000300_C0000300);
        chk("recover_lrclk", cap_ws[63:0], WS_EXP);
        repeat (8) @(negedge clk);
        chk("recover_level", 64'(fifo_level), 64'd0);
        chk("recover_urun", 64'(urun_cnt), 64'd1);
        check_quiet("recover_quiet", 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
